// File: rtl/seq_shift_unit.sv
// Multi-cycle WIDTH-bit shifter. An operand is captured on start, shifted one bit per clock,
// and presented on dout with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; dout holds the last result
//   SHIFT | one 1-bit shift per clock while the down-counter runs to terminal count
//   DONE  | result valid on dout, done pulse, return to IDLE next edge
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic             lr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
  localparam logic [1:0]       MODE_ARI = 2'b01;
  localparam logic [1:0]       MODE_ROT = 2'b10;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_reg, sh_nxt, sh_one;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic             lr_q, lr_nxt;
  logic [1:0]       mode_q, mode_nxt;

  // One-bit shift of the working register for the latched direction and mode.
  // Mode 11 falls through to logical; arithmetic left is the same as logical left.
  always_comb begin
    sh_one = sh_reg;
    if (!lr_q) begin
      if (mode_q == MODE_ROT) sh_one = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]};
      else                    sh_one = {sh_reg[WIDTH-2:0], 1'b0};
    end else begin
      if (mode_q == MODE_ROT)      sh_one = {sh_reg[0], sh_reg[WIDTH-1:1]};
      else if (mode_q == MODE_ARI) sh_one = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
      else                         sh_one = {1'b0, sh_reg[WIDTH-1:1]};
    end
  end

  // Next-state and datapath load/shift decisions.
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh_reg;
    cnt_nxt   = cnt;
    lr_nxt    = lr_q;
    mode_nxt  = mode_q;
    case (state)
      IDLE: begin
        if (start) begin
          sh_nxt    = din;
          cnt_nxt   = amt;
          lr_nxt    = lr;
          mode_nxt  = mode;
          state_nxt = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sh_nxt  = sh_one;
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh_reg <= '0;
      cnt    <= '0;
      lr_q   <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      state  <= state_nxt;
      sh_reg <= sh_nxt;
      cnt    <= cnt_nxt;
      lr_q   <= lr_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    dout = sh_reg;
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=8, AMT_W=4): a vector table plus
// hand sequences for ignored starts and mid-operation reset. Expected results and
// done cycles are queued when stimulus is driven and popped when done rises.
module tb_seq_shift_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic [3:0] amt;
  logic       lr;
  logic [1:0] mode;
  logic [7:0] dout;
  logic       busy;
  logic       done;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  typedef struct {
    logic [7:0] dout;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic [3:0] amt;
    logic       lr;
    logic [1:0] mode;
    logic [7:0] res;
  } vec_t;
  vec_t vecs[12];

  seq_shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .amt   (amt),
    .lr    (lr),
    .mode  (mode),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done_queue_size", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("done_dout", dout, e.dout);
        check("done_cycle", cycle, e.cyc);
      end
    end
  end

  task automatic drive_start(input logic [7:0] d, input logic [3:0] a, input logic l,
                             input logic [1:0] m);
    din = d; amt = a; lr = l; mode = m; start = 1'b1;
  endtask

  task automatic run_op(input logic [7:0] d, input logic [3:0] a, input logic l,
                        input logic [1:0] m, input logic [7:0] res);
    int nb;
    exp_t e;
    @(negedge clk);
    drive_start(d, a, l, m);
    e.dout = res;
    e.cyc  = cycle + 1 + int'(a);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    din = ~d; amt = ~a; lr = ~l; mode = ~m;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", nb, int'(a) + 1);
    @(negedge clk);
    @(negedge clk);
    check("hold_dout", dout, res);
  endtask

  initial begin
    vecs[0]  = '{8'h96, 4'd1,  1'b0, 2'b00, 8'h2C};
    vecs[1]  = '{8'h96, 4'd3,  1'b1, 2'b00, 8'h12};
    vecs[2]  = '{8'h96, 4'd3,  1'b1, 2'b01, 8'hF2};
    vecs[3]  = '{8'h96, 4'd3,  1'b0, 2'b10, 8'hB4};
    vecs[4]  = '{8'h96, 4'd8,  1'b1, 2'b10, 8'h96};
    vecs[5]  = '{8'h96, 4'd12, 1'b0, 2'b10, 8'h69};
    vecs[6]  = '{8'h96, 4'd0,  1'b0, 2'b00, 8'h96};
    vecs[7]  = '{8'h96, 4'd12, 1'b0, 2'b00, 8'h00};
    vecs[8]  = '{8'h96, 4'd2,  1'b0, 2'b01, 8'h58};
    vecs[9]  = '{8'h96, 4'd2,  1'b1, 2'b11, 8'h25};
    vecs[10] = '{8'h96, 4'd15, 1'b1, 2'b01, 8'hFF};
    vecs[11] = '{8'h96, 4'd1,  1'b1, 2'b10, 8'h4B};

    // Reset, with start held high to show reset dominates it.
    rst = 1'b1; start = 1'b1; din = 8'hFF; amt = 4'd2; lr = 1'b0; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", dout, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].din, vecs[i].amt, vecs[i].lr, vecs[i].mode, vecs[i].res);

    // Starts during SHIFT and during DONE of a logical-left-by-3 must be ignored.
    begin
      exp_t e;
      @(negedge clk);
      drive_start(8'h96, 4'd3, 1'b0, 2'b00);
      e.dout = 8'hB0;
      e.cyc  = cycle + 4;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      drive_start(8'hFF, 4'd0, 1'b1, 2'b10);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ign_busy_in_done", busy, 1'b1);
      check("ign_done_in_done", done, 1'b1);
      drive_start(8'hFF, 4'd1, 1'b1, 2'b10);
      @(negedge clk);
      start = 1'b0;
      check("ign_busy_after", busy, 1'b0);
      repeat (3) @(negedge clk);
      check("ign_hold_dout", dout, 8'hB0);
    end

    // Reset at E2 of an amt=5 operation: result discarded, no done pulse.
    @(negedge clk);
    drive_start(8'h96, 4'd5, 1'b0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_dout", dout, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_idle_busy", busy, 1'b0);
    run_op(8'h96, 4'd3, 1'b1, 2'b10, 8'hD2);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
